// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and default frame shape.
// The RX side imports the same package so both ends agree on framing.
package uart_tx_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;

   localparam int UART_DATA_WIDTH = 8;
   localparam int UART_STOP_BITS  = 1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Host/serializer-side signal bundle of the UART TX frame controller.
// master = host plus serializer, slave = frame controller.
interface uart_tx_ctrl_if #(
   parameter int DATA_WIDTH = uart_tx_ctrl_pkg::UART_DATA_WIDTH
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  ser_done;
   logic                  ser_data;
   logic                  ser_en;
   logic                  busy;
   logic                  TX_OUT;

   modport master (
      output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done, ser_data,
      input  ser_en, busy, TX_OUT
   );

   modport slave (
      input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done, ser_data,
      output ser_en, busy, TX_OUT
   );
endinterface

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Combinational parity generator: even parity (XOR of data) or odd parity (XNOR).
module uart_parity_calc #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   output logic                  par_bit
);

   // XOR reduction gives the even-parity bit; odd parity is its complement
   always_comb begin
      par_bit = (^data) ^ par_typ;
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: sequences start, data (via serializer), parity and stop bits.
// One bit per CLK cycle; TX_OUT is decoded from registered state plus the serializer flop.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | line high, waiting for Data_Valid (serializer loads here)
//  START  | start bit (line low), one cycle
//  DATA   | serializer shifting, ser_en high, leave on ser_done
//  PARITY | latched parity bit, one cycle (only when PAR_EN was set)
//  STOP   | line high for STOP_BITS cycles
import uart_tx_ctrl_pkg::*;

module uart_tx_ctrl #(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int STOP_BITS  = UART_STOP_BITS
) (
   input  logic         CLK,
   input  logic         RST,
   uart_tx_ctrl_if.slave bus
);

   localparam int       CW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic     STOP_LAST = 1'(STOP_BITS - 1);

   uart_state_t   state;
   uart_state_t   state_nxt;
   logic          par_bit_calc;
   logic          par_bit_q;
   logic          par_en_q;
   logic          stop_cnt;
   logic [CW-1:0] data_left;
   logic          tx_d;
   logic          busy_d;
   logic          ser_en_d;

   // Parity type is folded into the latched parity bit, so only the bit and PAR_EN are held
   uart_parity_calc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .data    (bus.P_DATA),
      .par_typ (bus.PAR_TYP),
      .par_bit (par_bit_calc)
   );

   // Next-state logic, one state per bit time
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (bus.Data_Valid) state_nxt = ST_START;
         ST_START:  state_nxt = ST_DATA;
         ST_DATA:   if (bus.ser_done) state_nxt = par_en_q ? ST_PARITY : ST_STOP;
         ST_PARITY: state_nxt = ST_STOP;
         ST_STOP:   if (stop_cnt == STOP_LAST) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // State register plus frame context latched on accept
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= ST_IDLE;
         par_bit_q <= 1'b0;
         par_en_q  <= 1'b0;
         stop_cnt  <= 1'b0;
         data_left <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && bus.Data_Valid) begin
            par_bit_q <= par_bit_calc;
            par_en_q  <= bus.PAR_EN;
         end
         stop_cnt <= (state == ST_STOP) ? stop_cnt + 1'b1 : 1'b0;
         if (state == ST_START)
            data_left <= CW'(DATA_WIDTH - 1);
         else if (state == ST_DATA && data_left != '0)
            data_left <= data_left - 1'b1;
      end
   end

   // Output decode from registered state; ser_data is itself a serializer flop
   always_comb begin
      tx_d     = UART_IDLE_LEVEL;
      busy_d   = (state != ST_IDLE);
      ser_en_d = (state == ST_DATA);
      case (state)
         ST_START:  tx_d = UART_START_LEVEL;
         ST_DATA:   tx_d = bus.ser_data;
         ST_PARITY: tx_d = par_bit_q;
         default:   tx_d = UART_IDLE_LEVEL;
      endcase
   end

   assign bus.TX_OUT = tx_d;
   assign bus.busy   = busy_d;
   assign bus.ser_en = ser_en_d;

   // Serializer must report its last bit by the DATA_WIDTH-th DATA cycle
   a_data_len: assert property (@(posedge CLK) disable iff (!RST)
      (state == ST_DATA && data_left == '0) |-> bus.ser_done);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two controllers (1 and 2 stop bits) each paired with a
// behavioural serializer; expected per-cycle {TX_OUT,busy,ser_en} go into queues
// and a negedge monitor pops and compares while a frame is on the line.
module tb_uart_tx_ctrl;

   logic       CLK;
   logic       RST;
   logic [7:0] p_data;
   logic       par_en;
   logic       par_typ;
   logic [1:0] dv;
   logic [1:0] busy_a, en_a, tx_a, done_a, sdat_a;
   logic [7:0] sh  [2];
   logic [2:0] cnt [2];

   logic [2:0] q0[$];
   logic [2:0] q1[$];
   int         n_vec;
   int         n_miss;
   int         cyc;

   uart_tx_ctrl_if #(.DATA_WIDTH(8)) bif1 ();
   uart_tx_ctrl_if #(.DATA_WIDTH(8)) bif2 ();

   uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut (.CLK(CLK), .RST(RST), .bus(bif1));
   uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (.CLK(CLK), .RST(RST), .bus(bif2));

   assign bif1.P_DATA     = p_data;
   assign bif1.PAR_EN     = par_en;
   assign bif1.PAR_TYP    = par_typ;
   assign bif1.Data_Valid = dv[0];
   assign bif1.ser_done   = done_a[0];
   assign bif1.ser_data   = sdat_a[0];
   assign bif2.P_DATA     = p_data;
   assign bif2.PAR_EN     = par_en;
   assign bif2.PAR_TYP    = par_typ;
   assign bif2.Data_Valid = dv[1];
   assign bif2.ser_done   = done_a[1];
   assign bif2.ser_data   = sdat_a[1];

   assign busy_a = {bif2.busy,   bif1.busy};
   assign en_a   = {bif2.ser_en, bif1.ser_en};
   assign tx_a   = {bif2.TX_OUT, bif1.TX_OUT};
   assign done_a = {(cnt[1] == 3'd7), (cnt[0] == 3'd7)};
   assign sdat_a = {sh[1][0], sh[0][0]};

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge CLK);
         cyc = cyc + 1;
      end
   end

   // Behavioural LSB-first serializer, loads when the controller is not busy
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int k = 0; k < 2; k++) begin
            sh[k]  <= 8'h00;
            cnt[k] <= 3'd0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (dv[k] && !busy_a[k]) begin
               sh[k]  <= p_data;
               cnt[k] <= 3'd0;
            end else if (en_a[k]) begin
               sh[k]  <= sh[k] >> 1;
               cnt[k] <= done_a[k] ? 3'd0 : cnt[k] + 3'd1;
            end
         end
      end
   end

   // Monitor: pop one expected entry per busy cycle and per frame-ending idle cycle
   initial begin
      logic [1:0] prev_busy;
      logic [2:0] act;
      logic [2:0] exp_v;
      bit         empty;
      prev_busy = 2'b00;
      forever begin
         @(negedge CLK);
         for (int k = 0; k < 2; k++) begin
            if (busy_a[k] || prev_busy[k]) begin
               act   = {tx_a[k], busy_a[k], en_a[k]};
               empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
               n_vec = n_vec + 1;
               if (empty) begin
                  n_miss = n_miss + 1;
                  $display("FAIL frame_dut%0d cyc=%0d unexpected output {tx,busy,en}=%b, no entry expected", k, cyc, act);
               end else begin
                  exp_v = (k == 0) ? q0.pop_front() : q1.pop_front();
                  if (act !== exp_v) begin
                     n_miss = n_miss + 1;
                     $display("FAIL frame_dut%0d cyc=%0d {tx,busy,en} got=%b want=%b", k, cyc, act, exp_v);
                  end
               end
            end
         end
         prev_busy = busy_a;
      end
   end

   task automatic push(input int k, input logic [2:0] v);
      if (k == 0) q0.push_back(v);
      else        q1.push_back(v);
   endtask

   task automatic push_frame(input int k, input logic [7:0] d, input logic pe,
                             input logic par_exp, input int nstop);
      push(k, 3'b010);
      for (int i = 0; i < 8; i++) push(k, {d[i], 2'b11});
      if (pe) push(k, {par_exp, 2'b10});
      for (int i = 0; i < nstop; i++) push(k, 3'b110);
      push(k, 3'b100);
   endtask

   // Called just after a rising edge; returns just after the accepting edge
   task automatic issue(input int k, input logic [7:0] d, input logic pe, input logic pt,
                        input logic par_exp, input int nstop);
      push_frame(k, d, pe, par_exp, nstop);
      p_data  = d;
      par_en  = pe;
      par_typ = pt;
      dv[k]   = 1'b1;
      @(posedge CLK);
      #1 dv[k] = 1'b0;
   endtask

   task automatic drain(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge CLK);
         if (q0.size() == 0 && q1.size() == 0 && busy_a == 2'b00) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
      if (!ok) begin
         n_vec  = n_vec + 1;
         n_miss = n_miss + 1;
         $display("FAIL %s timeout: busy=%b pending=%0d/%0d, want idle and 0/0", name, busy_a, q0.size(), q1.size());
         q0.delete();
         q1.delete();
      end
   endtask

   task automatic chk(input string name, input logic act, input logic exp_v);
      n_vec = n_vec + 1;
      if (act !== exp_v) begin
         n_miss = n_miss + 1;
         $display("FAIL %s got=%b want=%b", name, act, exp_v);
      end
   endtask

   initial begin
      n_vec   = 0;
      n_miss  = 0;
      RST     = 1'b0;
      dv      = 2'b00;
      p_data  = 8'h00;
      par_en  = 1'b0;
      par_typ = 1'b0;
      #2;
      chk("reset_tx",     tx_a[0],   1'b1);
      chk("reset_busy",   busy_a[0], 1'b0);
      chk("reset_ser_en", en_a[0],   1'b0);
      chk("reset_tx2",    tx_a[1],   1'b1);
      chk("reset_busy2",  busy_a[1], 1'b0);
      @(posedge CLK);
      @(posedge CLK);
      #2 RST = 1'b1;
      @(posedge CLK);
      #1;

      // 1: 0xA5 even parity -> parity bit 0
      issue(0, 8'hA5, 1'b1, 1'b0, 1'b0, 1);
      drain("s1_a5_even");
      // 2: 0xA5 odd parity -> parity bit 1
      issue(0, 8'hA5, 1'b1, 1'b1, 1'b1, 1);
      drain("s2_a5_odd");
      // 3: 0x01 no parity, 10-cycle frame
      issue(0, 8'h01, 1'b0, 1'b0, 1'b0, 1);
      drain("s3_01_nopar");
      // 4: two stop bits, 0xFF even parity -> 0
      issue(1, 8'hFF, 1'b1, 1'b0, 1'b0, 2);
      drain("s4_ff_2stop");

      // 5: Data_Valid held, 0x3C then 0xC3, inputs disturbed mid-frame
      push_frame(0, 8'h3C, 1'b1, 1'b0, 1);
      push_frame(0, 8'hC3, 1'b1, 1'b0, 1);
      p_data  = 8'h3C;
      par_en  = 1'b1;
      par_typ = 1'b0;
      dv[0]   = 1'b1;
      @(posedge CLK);
      #1;
      p_data  = 8'hFF;
      par_typ = 1'b1;
      par_en  = 1'b0;
      @(posedge CLK);
      #1 p_data = 8'hC3;
      repeat (3) @(posedge CLK);
      #1;
      par_typ = 1'b0;
      par_en  = 1'b1;
      repeat (8) @(posedge CLK);
      #1 dv[0] = 1'b0;
      drain("s5_back_to_back");

      // 6: reset during the 4th DATA cycle
      push(0, 3'b010);
      push(0, 3'b111);
      push(0, 3'b011);
      push(0, 3'b111);
      push(0, 3'b100);
      p_data = 8'hA5;
      par_en = 1'b0;
      dv[0]  = 1'b1;
      @(posedge CLK);
      #1 dv[0] = 1'b0;
      repeat (4) @(posedge CLK);
      #1 chk("s6_in_data", en_a[0], 1'b1);
      #1 RST = 1'b0;
      #1;
      chk("s6_rst_tx",     tx_a[0],   1'b1);
      chk("s6_rst_busy",   busy_a[0], 1'b0);
      chk("s6_rst_ser_en", en_a[0],   1'b0);
      @(posedge CLK);
      @(posedge CLK);
      #2 RST = 1'b1;
      @(posedge CLK);
      #1;
      issue(0, 8'h55, 1'b1, 1'b1, 1'b1, 1);
      drain("s6_after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL global_timeout reached at t=%0t, want bench completion", $time);
      $fatal(1);
   end

endmodule
